comp_nbs_pipe: RTL and testbench

COMP_NBS_PIPE -- requirements
Module: comp_nbs_pipe

---
 rtl/comp_nbs_pipe_if.sv | 31 +++
 rtl/comp_nbs_pipe.sv | 176 +++++++++++++++++
 tb/tb_comp_nbs_pipe.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_nbs_pipe_if.sv
// Handshake bundle for comp_nbs_pipe: operand/command beat in, flags/result beat out.
// The master drives operands and out_ready; the slave (the pipeline) drives in_ready and results.
interface comp_nbs_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             sign;
   logic [1:0]       mode;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic             eq;
   logic             neq;
   logic             grt;
   logic             lss;
   logic [WIDTH-1:0] res;
   logic             out_last;

   modport master (
      output in_valid, sign, mode, op1, op2, in_last, out_ready,
      input  in_ready, out_valid, eq, neq, grt, lss, res, out_last
   );

   modport slave (
      input  in_valid, sign, mode, op1, op2, in_last, out_ready,
      output in_ready, out_valid, eq, neq, grt, lss, res, out_last
   );
endinterface

// File: rtl/comp_nbs_pipe.sv
// Two-stage compare/min/max/accumulate-max pipeline with valid/ready flow control.
// S1 captures the accepted beat, S2 holds the computed flags and result.
module comp_nbs_pipe #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           resetn,
   comp_nbs_pipe_if.slave bus,
   output logic           dbg_acc_state
);

   typedef enum logic {
      ACC_IDLE  = 1'b0,
      ACC_INPKT = 1'b1
   } acc_state_t;

   localparam logic [1:0] MODE_CMP = 2'd0;
   localparam logic [1:0] MODE_MIN = 2'd1;
   localparam logic [1:0] MODE_MAX = 2'd2;
   localparam logic [1:0] MODE_ACC = 2'd3;

   logic             rdy_en;
   logic             s1_valid;
   logic             s1_sign;
   logic [1:0]       s1_mode;
   logic [WIDTH-1:0] s1_op1;
   logic [WIDTH-1:0] s1_op2;
   logic             s1_last;

   logic             s2_valid;
   logic             s2_eq;
   logic             s2_neq;
   logic             s2_grt;
   logic             s2_lss;
   logic [WIDTH-1:0] s2_res;
   logic             s2_last;

   acc_state_t       state_q;
   acc_state_t       state_d;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   logic             s2_adv;
   logic             in_fire;
   logic             s1_move;

   logic [WIDTH-1:0] rhs;
   logic signed [WIDTH:0] lhs_x;
   logic signed [WIDTH:0] rhs_x;
   logic             c_eq;
   logic             c_grt;
   logic             c_lss;

   logic             nx_eq;
   logic             nx_grt;
   logic             nx_lss;
   logic [WIDTH-1:0] nx_res;
   logic             nx_last;

   // A beat transfers on any rising edge where valid and ready are both high;
   // valid never waits for ready, and ready is gated off until the first edge after reset.
   assign s2_adv       = !s2_valid || bus.out_ready;
   assign bus.in_ready = rdy_en && (!s1_valid || !s2_valid || bus.out_ready);
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign s1_move      = s1_valid && s2_adv;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mode  <= MODE_CMP;
         s1_op1   <= '0;
         s1_op2   <= '0;
         s1_last  <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_sign  <= bus.sign;
         s1_mode  <= bus.mode;
         s1_op1   <= bus.op1;
         s1_op2   <= bus.op2;
         s1_last  <= bus.in_last;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // In ACC the right-hand side of the compare is the running maximum, not op2.
   assign rhs   = (s1_mode == MODE_ACC) ? acc_q : s1_op2;
   assign lhs_x = {s1_sign & s1_op1[WIDTH-1], s1_op1};
   assign rhs_x = {s1_sign & rhs[WIDTH-1], rhs};
   assign c_eq  = (s1_op1 == rhs);
   assign c_grt = (lhs_x > rhs_x);
   assign c_lss = !c_eq && !c_grt;

   always_comb begin
      nx_eq   = c_eq;
      nx_grt  = c_grt;
      nx_lss  = c_lss;
      nx_res  = s1_op1;
      nx_last = 1'b0;
      state_d = state_q;
      acc_d   = acc_q;
      case (s1_mode)
         MODE_MIN: if (c_grt) nx_res = s1_op2;
         MODE_MAX: if (c_lss) nx_res = s1_op2;
         MODE_ACC: begin
            nx_last = s1_last;
            if (state_q == ACC_IDLE) begin
               nx_eq  = 1'b1;
               nx_grt = 1'b0;
               nx_lss = 1'b0;
               nx_res = s1_op1;
            end else if (c_grt) begin
               nx_res = s1_op1;
            end else begin
               nx_res = acc_q;
            end
            if (s1_move) begin
               acc_d   = nx_res;
               state_d = s1_last ? ACC_IDLE : ACC_INPKT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ACC_IDLE;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s2_valid <= 1'b0;
         s2_eq    <= 1'b0;
         s2_neq   <= 1'b0;
         s2_grt   <= 1'b0;
         s2_lss   <= 1'b0;
         s2_res   <= '0;
         s2_last  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_eq   <= nx_eq;
            s2_neq  <= !nx_eq;
            s2_grt  <= nx_grt;
            s2_lss  <= nx_lss;
            s2_res  <= nx_res;
            s2_last <= nx_last;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.eq        = s2_eq;
   assign bus.neq       = s2_neq;
   assign bus.grt       = s2_grt;
   assign bus.lss       = s2_lss;
   assign bus.res       = s2_res;
   assign bus.out_last  = s2_last;
   assign dbg_acc_state = state_q;

endmodule

// File: tb/tb_comp_nbs_pipe.sv
// Bench for comp_nbs_pipe: directed table, backpressure and reset sequences, random traffic
// against a value-level model, and an exhaustive 8-bit compare sweep on parallel instances.
module tb_comp_nbs_pipe;
   localparam int W  = 32;
   localparam int EW = W + 5;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_out = 0;
   bit exh_go = 1'b0;
   int exh_done_cnt = 0;

   comp_nbs_pipe_if #(.WIDTH(W)) dif();
   logic dbg32;
   comp_nbs_pipe #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(dif.slave), .dbg_acc_state(dbg32));

   typedef struct {
      bit          sign;
      logic [1:0]  mode;
      logic [31:0] op1;
      logic [31:0] op2;
      bit          last;
      bit          eq;
      bit          grt;
      bit          lss;
      bit          olast;
      logic [31:0] res;
   } vec_t;

   logic [W-1:0]  ref_acc = '0;
   bit            ref_inpkt = 1'b0;
   logic [EW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic longint sval(input bit s, input logic [63:0] x, input int w);
      if (s && x[w-1]) return longint'(x) - (longint'(1) << w);
      return longint'(x);
   endfunction

   // Expected {eq, neq, grt, lss, out_last, res} for an accepted beat, in arrival order.
   function automatic logic [EW-1:0] model_beat(input bit s, input logic [1:0] m,
                                                input logic [W-1:0] a_raw, input logic [W-1:0] b_raw,
                                                input bit last);
      longint a, b, c;
      bit e, g, l;
      logic [W-1:0] r;
      a = sval(s, 64'(a_raw), W);
      b = sval(s, 64'(b_raw), W);
      e = (a == b);
      g = (a > b);
      l = (a < b);
      r = a_raw;
      case (m)
         2'd1: if (b < a) r = b_raw;
         2'd2: if (b > a) r = b_raw;
         2'd3: begin
            if (!ref_inpkt) begin
               e = 1'b1; g = 1'b0; l = 1'b0;
               ref_acc = a_raw;
            end else begin
               c = sval(s, 64'(ref_acc), W);
               e = (a == c); g = (a > c); l = (a < c);
               if (a > c) ref_acc = a_raw;
            end
            r = ref_acc;
            ref_inpkt = !last;
         end
         default: ;
      endcase
      return {e, !e, g, l, (m == 2'd3) && last, r};
   endfunction

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 3));
         1: return ~32'($urandom_range(0, 3));
         2: return 32'h8000_0000 + 32'($urandom_range(0, 3));
         default: return 32'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      logic [EW-1:0] e_val;
      logic [EW-1:0] a_val;
      #1;
      if (resetn === 1'b1) begin
         if (dif.in_valid && dif.in_ready)
            exp_q.push_back(model_beat(dif.sign, dif.mode, dif.op1, dif.op2, dif.in_last));
         if (dif.out_valid && dif.out_ready) begin
            n_vec++;
            n_out++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL spurious_beat: got res=%h, expected no beat", dif.res);
            end else begin
               e_val = exp_q.pop_front();
               a_val = {dif.eq, dif.neq, dif.grt, dif.lss, dif.out_last, dif.res};
               if (a_val !== e_val) begin
                  n_err++;
                  $display("FAIL model_beat: got %h, expected %h", a_val, e_val);
               end
            end
         end
      end
   end

   // Exhaustive 8-bit CMP sweep, split over eight instances by sign and op1[7:6].
   for (genvar G = 0; G < 8; G++) begin : gx
      localparam bit         SG = (G % 2) == 1;
      localparam logic [1:0] HI = 2'(G / 2);
      comp_nbs_pipe_if #(.WIDTH(8)) xif();
      logic dbg8;
      logic [10:0] exp_q[$];
      comp_nbs_pipe #(.WIDTH(8)) ux (.clk(clk), .resetn(resetn), .bus(xif.slave), .dbg_acc_state(dbg8));

      initial begin
         xif.in_valid = 1'b0; xif.out_ready = 1'b1; xif.sign = 1'b0; xif.mode = 2'd0;
         xif.op1 = '0; xif.op2 = '0; xif.in_last = 1'b0;
         wait (exh_go);
         for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 256; b++) begin
               @(negedge clk);
               xif.in_valid = 1'b1;
               xif.sign     = SG;
               xif.op1      = {HI, 6'(a)};
               xif.op2      = 8'(b);
               xif.in_last  = (b % 7) == 0;
            end
         end
         @(negedge clk);
         xif.in_valid = 1'b0;
         repeat (6) @(negedge clk);
         #2;
         chk("exh_drain", 64'(exp_q.size()), 64'd0);
         chk("exh_fsm_idle", 64'(dbg8), 64'd0);
         exh_done_cnt++;
      end

      always @(negedge clk) begin
         longint a, b;
         logic [10:0] e;
         #1;
         if (resetn === 1'b1) begin
            if (xif.in_valid && xif.in_ready) begin
               a = sval(xif.sign, 64'(xif.op1), 8);
               b = sval(xif.sign, 64'(xif.op2), 8);
               exp_q.push_back({a == b, a > b, a < b, xif.op1});
            end
            if (xif.out_valid && xif.out_ready) begin
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL exh_spurious: got res=%h, expected no beat", xif.res);
               end else begin
                  e = exp_q.pop_front();
                  if ({xif.eq, xif.grt, xif.lss, xif.res} !== e || xif.neq !== !e[10] || xif.out_last !== 1'b0) begin
                     n_err++;
                     $display("FAIL exh_cmp: got %b%b%b%b res=%h, expected %b%b%b res=%h",
                              xif.eq, xif.neq, xif.grt, xif.lss, xif.res, e[10], e[9], e[8], e[7:0]);
                  end
               end
               n_vec++;
               if ($countones({xif.eq, xif.grt, xif.lss}) != 1) begin
                  n_err++;
                  $display("FAIL exh_onehot: got %b%b%b, expected one-hot", xif.eq, xif.grt, xif.lss);
               end
            end
         end
      end
   end

   task automatic drive_beat(input bit s, input logic [1:0] m, input logic [31:0] a,
                             input logic [31:0] b, input bit last);
      int k = 0;
      @(negedge clk);
      dif.in_valid = 1'b1; dif.sign = s; dif.mode = m; dif.op1 = a; dif.op2 = b; dif.in_last = last;
      #1;
      while (!dif.in_ready && k < 20) begin
         @(negedge clk); #1; k++;
      end
      if (k >= 20) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", k);
      end
      @(negedge clk);
      dif.in_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      drive_beat(v.sign, v.mode, v.op1, v.op2, v.last);
      dif.op1 = 32'($urandom); dif.op2 = 32'($urandom); dif.mode = 2'($urandom_range(0, 3));
      dif.sign = ~v.sign; dif.in_last = ~v.last;
      #1;
      chk($sformatf("vec%0d_latency_early", idx), 64'(dif.out_valid), 64'd0);
      @(negedge clk); #1;
      chk($sformatf("vec%0d_latency", idx), 64'(dif.out_valid), 64'd1);
      chk($sformatf("vec%0d_flags", idx), 64'({dif.eq, dif.neq, dif.grt, dif.lss, dif.out_last}),
          64'({v.eq, !v.eq, v.grt, v.lss, v.olast}));
      chk($sformatf("vec%0d_res", idx), 64'(dif.res), 64'(v.res));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected $finish before 1ms");
      $fatal(1);
   end

   initial begin
      vec_t tbl[16];
      int   k;
      int   idx;
      int   base_out;
      bit   hs;
      logic [W+5:0] held;

      tbl[0]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF};
      tbl[1]  = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF};
      tbl[2]  = '{1'b0, 2'd1, 32'd5,         32'd9,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5};
      tbl[3]  = '{1'b1, 2'd2, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{1'b1, 2'd0, 32'd7,         32'd7,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7};
      tbl[5]  = '{1'b1, 2'd1, 32'hFFFF_FFFE, 32'd3,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE};
      tbl[6]  = '{1'b0, 2'd2, 32'hFFFF_FFFE, 32'd3,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE};
      tbl[7]  = '{1'b0, 2'd1, 32'd9,         32'd9,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd9};
      tbl[8]  = '{1'b1, 2'd3, 32'd3,         32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3};
      tbl[9]  = '{1'b1, 2'd3, 32'hFFFF_FFF9, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd3};
      tbl[10] = '{1'b1, 2'd3, 32'd10,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd10};
      tbl[11] = '{1'b1, 2'd3, 32'd10,        32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd10};
      tbl[12] = '{1'b1, 2'd3, 32'hFFFF_FFF0, 32'd99,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0};
      tbl[13] = '{1'b0, 2'd0, 32'd2,         32'd1,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2};
      tbl[14] = '{1'b1, 2'd3, 32'hFFFF_FFF5, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF5};
      tbl[15] = '{1'b1, 2'd2, 32'd3,         32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3};

      // clock/reset
      resetn = 1'b0;
      dif.in_valid = 1'b0; dif.out_ready = 1'b1; dif.sign = 1'b0; dif.mode = 2'd0;
      dif.op1 = '0; dif.op2 = '0; dif.in_last = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_flags", 64'({dif.out_valid, dif.eq, dif.neq, dif.grt, dif.lss, dif.out_last, dif.in_ready}), 64'd0);
      chk("reset_res", 64'(dif.res), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("ready_at_release", 64'(dif.in_ready), 64'd0);
      @(negedge clk); #1;
      chk("ready_after_release", 64'(dif.in_ready), 64'd1);

      exh_go = 1'b1;
      k = 0;
      while (exh_done_cnt < 8 && k < 20000) begin
         @(negedge clk); k++;
      end
      #3;
      chk("exh_complete", 64'(exh_done_cnt), 64'd8);

      for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

      // backpressure: 3 beats offered over 4 stalled cycles
      @(negedge clk);
      dif.out_ready = 1'b0;
      idx = 0;
      held = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         dif.in_valid = 1'b1; dif.sign = 1'b0; dif.mode = 2'd0;
         dif.op1 = 32'(100 * (idx + 1)); dif.op2 = 32'd150; dif.in_last = 1'b0;
         #1;
         if (c == 2) held = {dif.out_valid, dif.eq, dif.neq, dif.grt, dif.lss, dif.out_last, dif.res};
         if (c == 3) chk("stall_hold", 64'({dif.out_valid, dif.eq, dif.neq, dif.grt, dif.lss, dif.out_last, dif.res}), 64'(held));
         if (dif.in_ready) idx++;
      end
      chk("bp_accepted", 64'(idx), 64'd2);
      chk("bp_ready_low", 64'(dif.in_ready), 64'd0);
      chk("bp_stalled_valid", 64'(held[W+5]), 64'd1);
      base_out = n_out;
      @(negedge clk);
      dif.out_ready = 1'b1;
      #1;
      chk("bp_resume_ready", 64'(dif.in_ready), 64'd1);
      @(negedge clk);
      dif.in_valid = 1'b0;
      k = 0;
      while (n_out - base_out < 3 && k < 20) begin
         @(negedge clk); #2; k++;
      end
      repeat (3) @(negedge clk);
      #2;
      chk("bp_delivered", 64'(n_out - base_out), 64'd3);

      // reset in the middle of an ACC packet with two beats in flight
      drive_beat(1'b1, 2'd3, 32'd5, 32'd0, 1'b0);
      repeat (3) @(negedge clk);
      dif.out_ready = 1'b0;
      drive_beat(1'b1, 2'd3, 32'd7, 32'd0, 1'b0);
      drive_beat(1'b1, 2'd3, 32'd9, 32'd0, 1'b0);
      #1;
      chk("rst_pre_inflight", 64'(dif.out_valid), 64'd1);
      @(negedge clk);
      resetn = 1'b0;
      exp_q.delete();
      ref_inpkt = 1'b0;
      ref_acc = '0;
      #1;
      chk("rst_async_flags", 64'({dif.out_valid, dif.eq, dif.neq, dif.grt, dif.lss, dif.out_last, dif.in_ready}), 64'd0);
      chk("rst_async_res", 64'(dif.res), 64'd0);
      chk("rst_fsm_idle", 64'(dbg32), 64'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      dif.out_ready = 1'b1;
      @(negedge clk); #1;
      chk("rst_ready_rise", 64'(dif.in_ready), 64'd1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1;
         chk("rst_no_stale", 64'(dif.out_valid), 64'd0);
      end
      drive_beat(1'b1, 2'd3, 32'hFFFF_FFF0, 32'd0, 1'b1);
      #1;
      @(negedge clk); #1;
      chk("rst_acc_reinit", 64'({dif.out_valid, dif.eq, dif.grt, dif.lss, dif.out_last, dif.res}),
          64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0}));

      // random traffic against the model
      hs = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!dif.in_valid || hs) begin
            dif.in_valid = ($urandom_range(0, 9) < 7);
            dif.sign     = 1'($urandom_range(0, 1));
            dif.mode     = 2'($urandom_range(0, 3));
            dif.op1      = rnd_op();
            dif.op2      = rnd_op();
            dif.in_last  = ($urandom_range(0, 3) == 0);
         end
         dif.out_ready = ($urandom_range(0, 9) < 6);
         #1;
         hs = dif.in_valid && dif.in_ready;
      end
      @(negedge clk);
      dif.in_valid = 1'b0;
      dif.out_ready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(negedge clk); #2; k++;
      end
      chk("final_drain", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
